// File: rtl/wam_pkg.sv
// Shared definitions for the whac-a-mole PS/2 keyboard front end:
// scan-code set 2 constants, receive FSM encoding and key lookup helper.
package wam_pkg;

    // Hole keys '1'..'8' in scan-code set 2
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;

    // Control keys and protocol bytes
    localparam logic [7:0] SC_ESC      = 8'h76;
    localparam logic [7:0] SC_LEFT     = 8'h6B;  // only meaningful after E0
    localparam logic [7:0] SC_RIGHT    = 8'h74;  // only meaningful after E0
    localparam logic [7:0] SC_E0       = 8'hE0;
    localparam logic [7:0] SC_F0       = 8'hF0;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_RECV  = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_t;

    // Map a scan code to a hole index: returns {hit, index[2:0]}
    function automatic logic [3:0] hole_lookup(input logic [7:0] sc);
        logic [3:0] res;
        case (sc)
            SC_1:    res = 4'b1_000;
            SC_2:    res = 4'b1_001;
            SC_3:    res = 4'b1_010;
            SC_4:    res = 4'b1_011;
            SC_5:    res = 4'b1_100;
            SC_6:    res = 4'b1_101;
            SC_7:    res = 4'b1_110;
            SC_8:    res = 4'b1_111;
            default: res = 4'b0_000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wam_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises the keyboard lines,
// detects falling clock edges, deserialises 11-bit frames and flags
// parity/framing errors and stalled frames.
module wam_ps2_rx
    import wam_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_vld,
    output logic       frm_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    rx_state_t              state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]             code_q, code_d;
    logic                   code_vld_q, code_vld_d;
    logic                   frm_err_q, frm_err_d;

    logic                   clk_cur;
    logic                   dat_cur;
    logic                   fe;
    logic [FRAME_BITS-1:0]  shift_in;
    logic                   frame_ok;

    assign clk_cur  = clk_sync_q[SYNC_STAGES-1];
    assign dat_cur  = dat_sync_q[SYNC_STAGES-1];
    assign fe       = clk_prev_q & ~clk_cur;
    // LSB first: the newest bit enters at the top, so after 11 shifts
    // bit 0 holds the start bit and bit 10 the stop bit.
    assign shift_in = {dat_cur, shift_q[FRAME_BITS-1:1]};
    assign frame_ok = ~shift_in[0] & shift_in[10] & (^shift_in[9:1]);

    // Synchroniser chains and the delayed clock used for edge detection
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
        clk_prev_d = clk_cur;
    end

    // Register all receiver state; reset drops any partial frame silently
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
            state_q    <= RX_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            to_cnt_q   <= '0;
            code_q     <= '0;
            code_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            to_cnt_q   <= to_cnt_d;
            code_q     <= code_d;
            code_vld_q <= code_vld_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // Frame FSM: the frame check is evaluated on the stop-bit edge so the
    // code_vld/frm_err pulse is registered and lands during the CHECK cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        to_cnt_d   = to_cnt_q;
        code_d     = code_q;
        code_vld_d = 1'b0;
        frm_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                to_cnt_d = '0;
                if (fe && !dat_cur) begin
                    state_d   = RX_RECV;
                    bit_cnt_d = 4'd1;
                    shift_d   = shift_in;
                end
            end
            RX_RECV: begin
                if (fe) begin
                    // an edge always beats a coincident timeout
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    to_cnt_d  = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = RX_CHECK;
                        if (frame_ok) begin
                            code_vld_d = 1'b1;
                            code_d     = shift_in[8:1];
                        end else begin
                            frm_err_d = 1'b1;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    frm_err_d = 1'b1;
                    state_d   = RX_IDLE;
                    to_cnt_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RX_CHECK: begin
                state_d = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign code     = code_q;
    assign code_vld = code_vld_q;
    assign frm_err  = frm_err_q;

endmodule

// File: rtl/wam_ps2.sv
// PS/2 keyboard front end for whac-a-mole: receives scan-code set 2 bytes
// and turns make/break sequences into switch/button equivalent levels.
module wam_ps2
    import wam_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] kb_sw,
    output logic       kb_lft,
    output logic       kb_rgt,
    output logic       kb_clr,
    output logic [7:0] code,
    output logic       code_vld,
    output logic       frm_err
);

    logic [7:0] rx_code;
    logic       rx_vld;
    logic       rx_err;

    logic       e0_q, e0_d;
    logic       f0_q, f0_d;
    logic [7:0] sw_q, sw_d;
    logic       lft_q, lft_d;
    logic       rgt_q, rgt_d;
    logic       kclr_q, kclr_d;
    logic [3:0] hole;
    logic       make;

    wam_ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .clr      (clr),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .code     (rx_code),
        .code_vld (rx_vld),
        .frm_err  (rx_err)
    );

    // Register decoder prefix flags and key levels
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            e0_q   <= 1'b0;
            f0_q   <= 1'b0;
            sw_q   <= '0;
            lft_q  <= 1'b0;
            rgt_q  <= 1'b0;
            kclr_q <= 1'b0;
        end else begin
            e0_q   <= e0_d;
            f0_q   <= f0_d;
            sw_q   <= sw_d;
            lft_q  <= lft_d;
            rgt_q  <= rgt_d;
            kclr_q <= kclr_d;
        end
    end

    // Scan-code decoder: E0/F0 arm prefixes, any other byte acts then clears them
    always_comb begin
        e0_d   = e0_q;
        f0_d   = f0_q;
        sw_d   = sw_q;
        lft_d  = lft_q;
        rgt_d  = rgt_q;
        kclr_d = 1'b0;
        hole   = hole_lookup(rx_code);
        make   = ~f0_q;
        if (rx_err) begin
            // a damaged byte may have been a prefix; do not let it pair up
            e0_d = 1'b0;
            f0_d = 1'b0;
        end else if (rx_vld) begin
            if (rx_code == SC_E0) begin
                e0_d = 1'b1;
            end else if (rx_code == SC_F0) begin
                f0_d = 1'b1;
            end else begin
                e0_d = 1'b0;
                f0_d = 1'b0;
                if (rx_code == SC_BAT_OK || rx_code == SC_BAT_FAIL) begin
                    // keyboard (re)plugged: nothing can still be held
                    sw_d  = '0;
                    lft_d = 1'b0;
                    rgt_d = 1'b0;
                end else if (e0_q) begin
                    if (rx_code == SC_LEFT) begin
                        lft_d = make;
                    end else if (rx_code == SC_RIGHT) begin
                        rgt_d = make;
                    end
                end else if (hole[3]) begin
                    sw_d[hole[2:0]] = make;
                end else if (rx_code == SC_ESC) begin
                    kclr_d = make;
                end
            end
        end
    end

    assign kb_sw    = sw_q;
    assign kb_lft   = lft_q;
    assign kb_rgt   = rgt_q;
    assign kb_clr   = kclr_q;
    assign code     = rx_code;
    assign code_vld = rx_vld;
    assign frm_err  = rx_err;

endmodule

// File: tb/tb_wam_ps2.sv
// Self-checking bench for wam_ps2: a byte-level vector table plus
// hand-written sequences for latency, timeout, reset and BAT handling.
module tb_wam_ps2;

    localparam int TO = 200;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] kb_sw;
    logic       kb_lft;
    logic       kb_rgt;
    logic       kb_clr;
    logic [7:0] code;
    logic       code_vld;
    logic       frm_err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int clr_cyc  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       bad;
        logic [7:0] sw;
        logic       lft;
        logic       rgt;
    } vec_t;
    vec_t vt[$];

    logic [10:0] frm;
    int          base;

    wam_ps2 #(
        .TIMEOUT_CYC (TO),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .kb_sw    (kb_sw),
        .kb_lft   (kb_lft),
        .kb_rgt   (kb_rgt),
        .kb_clr   (kb_clr),
        .code     (code),
        .code_vld (code_vld),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 ps2_dat = f[i];
            repeat (5) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (10) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (5) @(posedge clk);
        end
        #1 ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        if (!bad) exp_q.push_back(b);
        send_bits(mk_frame(b, bad), 11);
        repeat (10) @(posedge clk);
        $display("tx byte=%02h bad=%0d sw=%02h lft=%0d rgt=%0d", b, bad, kb_sw, kb_lft, kb_rgt);
    endtask

    function automatic void add(input logic [7:0] b, input logic bad, input logic [7:0] sw,
                                input logic lft, input logic rgt);
        vec_t v;
        v.b = b; v.bad = bad; v.sw = sw; v.lft = lft; v.rgt = rgt;
        vt.push_back(v);
    endfunction

    // Scoreboard: every received byte must match the oldest expected one
    always @(negedge clk) begin
        if (code_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_code_vld actual=%02h expected=none", code);
            end else begin
                check("scoreboard_code", {24'd0, code}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frm_err) err_cnt++;
        if (kb_clr)  clr_cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {kb_sw, kb_lft, kb_rgt, kb_clr, code, code_vld, frm_err}, 0);
        @(posedge clk); #1 clr = 1'b0;
        repeat (10) @(posedge clk);

        // Latency: code_vld one cycle after the stop-bit fe cycle, level one later
        exp_q.push_back(8'h16);
        frm = mk_frame(8'h16, 1'b0);
        check("frame16_parity", {21'd0, frm}, {21'd0, 11'b1_0_00010110_0});
        send_bits(frm, 10);
        @(posedge clk); #1 ps2_dat = 1'b1;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (SS) @(posedge clk);
        @(negedge clk);
        check("vld_in_fe_cycle", {31'd0, code_vld}, 0);
        @(negedge clk);
        check("vld_latency", {31'd0, code_vld}, 1);
        check("code_at_vld", {24'd0, code}, 32'h16);
        check("sw_before_update", {24'd0, kb_sw}, 0);
        @(negedge clk);
        check("sw_latency", {24'd0, kb_sw}, 1);
        check("vld_one_cycle", {31'd0, code_vld}, 0);
        repeat (8) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (10) @(posedge clk);

        // byte, bad-parity, expected sw, lft, rgt
        add(8'hF0, 0, 8'h01, 0, 0);
        add(8'h16, 0, 8'h00, 0, 0);
        add(8'h3E, 0, 8'h80, 0, 0);
        add(8'h26, 0, 8'h84, 0, 0);
        add(8'hF0, 0, 8'h84, 0, 0);
        add(8'h3E, 0, 8'h04, 0, 0);
        add(8'hE0, 0, 8'h04, 0, 0);
        add(8'h6B, 0, 8'h04, 1, 0);
        add(8'hE0, 0, 8'h04, 1, 0);
        add(8'h74, 0, 8'h04, 1, 1);
        add(8'hE0, 0, 8'h04, 1, 1);
        add(8'hF0, 0, 8'h04, 1, 1);
        add(8'h6B, 0, 8'h04, 0, 1);
        add(8'h6B, 0, 8'h04, 0, 1);
        add(8'hE0, 0, 8'h04, 0, 1);
        add(8'h6B, 0, 8'h04, 1, 1);
        add(8'hF0, 0, 8'h04, 1, 1);
        add(8'h6B, 0, 8'h04, 1, 1);
        add(8'hE0, 0, 8'h04, 1, 1);
        add(8'h74, 0, 8'h04, 1, 1);
        add(8'h1E, 1, 8'h04, 1, 1);
        add(8'h1E, 0, 8'h06, 1, 1);
        add(8'hE0, 0, 8'h06, 1, 1);
        add(8'hF0, 0, 8'h06, 1, 1);
        add(8'h6B, 1, 8'h06, 1, 1);
        add(8'h6B, 0, 8'h06, 1, 1);
        add(8'hE0, 0, 8'h06, 1, 1);
        add(8'hF0, 0, 8'h06, 1, 1);
        add(8'h6B, 0, 8'h06, 0, 1);
        add(8'hE0, 0, 8'h06, 0, 1);
        add(8'hF0, 0, 8'h06, 0, 1);
        add(8'h74, 0, 8'h06, 0, 0);
        for (int i = 0; i < vt.size(); i++) begin
            base = err_cnt;
            send_byte(vt[i].b, vt[i].bad);
            check($sformatf("v%0d_sw", i),  {24'd0, kb_sw},  {24'd0, vt[i].sw});
            check($sformatf("v%0d_lft", i), {31'd0, kb_lft}, {31'd0, vt[i].lft});
            check($sformatf("v%0d_rgt", i), {31'd0, kb_rgt}, {31'd0, vt[i].rgt});
            check($sformatf("v%0d_err", i), err_cnt - base,  {31'd0, vt[i].bad});
        end

        // Stalled frame: exactly one frm_err after the timeout, nothing else
        base = err_cnt;
        send_bits(mk_frame(8'h25, 1'b0), 5);
        repeat (2 * TO) @(posedge clk);
        $display("tx partial 5 bits, err pulses=%0d", err_cnt - base);
        check("timeout_err_once", err_cnt - base, 1);
        check("timeout_sw_kept", {24'd0, kb_sw}, 32'h06);

        // Esc make pulses kb_clr for one cycle; break does nothing
        base = clr_cyc;
        send_byte(8'h76, 1'b0);
        check("esc_make_pulse", clr_cyc - base, 1);
        check("esc_sw_kept", {24'd0, kb_sw}, 32'h06);
        base = clr_cyc;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h76, 1'b0);
        check("esc_break_none", clr_cyc - base, 0);

        // Reset mid-frame: outputs zero, partial frame lost without frm_err
        send_byte(8'h16, 1'b0);
        check("hold16", {24'd0, kb_sw}, 32'h07);
        base = err_cnt;
        send_bits(mk_frame(8'h25, 1'b0), 6);
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk);
        check("clr_outs", {kb_sw, kb_lft, kb_rgt, kb_clr, code, code_vld, frm_err}, 0);
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        repeat (2 * TO) @(posedge clk);
        $display("clr mid-frame, err pulses=%0d sw=%02h", err_cnt - base, kb_sw);
        check("clr_no_err", err_cnt - base, 0);
        check("clr_sw_zero", {24'd0, kb_sw}, 0);

        // BAT bytes release everything held
        send_byte(8'h16, 1'b0); send_byte(8'h1E, 1'b0);
        send_byte(8'h26, 1'b0); send_byte(8'h25, 1'b0);
        send_byte(8'h2E, 1'b0); send_byte(8'h36, 1'b0);
        send_byte(8'h3D, 1'b0); send_byte(8'h3E, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
        check("preset_ff", {24'd0, kb_sw, kb_lft, kb_rgt}, {24'd0, 8'hFF, 2'b11} >> 0);
        send_byte(8'hAA, 1'b0);
        check("bat_ok_clear", {22'd0, kb_sw, kb_lft, kb_rgt}, 0);
        send_byte(8'h36, 1'b0);
        check("make6", {24'd0, kb_sw}, 32'h20);
        send_byte(8'hFC, 1'b0);
        check("bat_fail_clear", {24'd0, kb_sw}, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
